// File: rtl/write_pack_ctrl.sv
// write_pack_ctrl
//   Takes accumulator results from the X_MESH compute-mesh rows and requantises
//   each value (arithmetic shift, optional ReLU, saturation to OUT_BITS). It
//   packs PACK = DATA_LEN/OUT_BITS values per word and writes complete words
//   into the X_MAC feature-map banks of every row.
//
//   Optional build macro WPC_ROUND_EN: when defined, values are rounded
//   half-up before the shift. When undefined, the shift truncates toward -inf.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   conf          one-cycle config strobe, honoured only in IDLE
//   st_addr       per-bank start address (bank b at bits b*ADDR_LEN)
//   linelen       values per row in this line
//   valid_mac     primary bank; unpooled mode also uses the next bank (mod X_MAC)
//   pooled        1: one value per beat (in_data_1); 0: 2x2 quad per beat (in_data_4)
//   shift_len     right-shift amount applied before saturation
//   is_relu       clamp negative results to 0
//   in_valid/in_ready  beat handshake; in_ready is high only while filling
//   in_data_4     quad per row, element k + 2*j + 4*row
//   in_data_1     single value per row
//   addra/data_a/wea   bank write port, bank b of row r at index r*X_MAC+b
//   busy          line in progress
//   done          one-cycle pulse after the last write of a line
//
// X_MAC must be at least 2 (unpooled mode writes two distinct banks).
module write_pack_ctrl #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 13,
    parameter int DATA_LEN     = 32,
    parameter int COM_DATALEN  = 24,
    parameter int OUT_BITS     = 8,
    parameter int MAX_LINE_LEN = 10,
    parameter int SHIFT_W      = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  conf,
    input  logic [ADDR_LEN*X_MAC-1:0]             st_addr,
    input  logic [MAX_LINE_LEN-1:0]               linelen,
    input  logic [$clog2(X_MAC)-1:0]              valid_mac,
    input  logic                                  pooled,
    input  logic [SHIFT_W-1:0]                    shift_len,
    input  logic                                  is_relu,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [4*COM_DATALEN*X_MESH-1:0]       in_data_4,
    input  logic [COM_DATALEN*X_MESH-1:0]         in_data_1,
    output logic [ADDR_LEN*X_MAC*X_MESH-1:0]      addra,
    output logic [DATA_LEN*X_MAC*X_MESH-1:0]      data_a,
    output logic [X_MAC*X_MESH-1:0]               wea,
    output logic                                  busy,
    output logic                                  done
);
    localparam int PACK = DATA_LEN / OUT_BITS;
    localparam int PW   = $clog2(PACK);
    localparam int VMW  = $clog2(X_MAC);
    localparam int IW   = COM_DATALEN + 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

    // Requantise one accumulator value. The working width is one bit wider
    // than the accumulator so the rounding add can never wrap.
    function automatic logic [OUT_BITS-1:0] quant(
        input logic [COM_DATALEN-1:0] x,
        input logic [SHIFT_W-1:0]     sh,
        input logic                   relu
    );
        logic signed [IW-1:0] xe;
        logic signed [IW-1:0] s;
        logic signed [IW-1:0] qmax;
        logic signed [IW-1:0] qmin;
        logic [OUT_BITS-1:0]  res;
        qmax = IW'((2 ** (OUT_BITS-1)) - 1);
        qmin = IW'(-(2 ** (OUT_BITS-1)));
        xe   = {x[COM_DATALEN-1], x};
`ifdef WPC_ROUND_EN
        if (sh != '0)
            xe = xe + (IW'(1) <<< (sh - SHIFT_W'(1)));
`endif
        s = xe >>> sh;
        if (s > qmax)
            res = qmax[OUT_BITS-1:0];
        else if (s[IW-1] && relu)
            res = '0;
        else if (s < qmin)
            res = qmin[OUT_BITS-1:0];
        else
            res = s[OUT_BITS-1:0];
        return res;
    endfunction

    state_t                                     state;
    logic [MAX_LINE_LEN-1:0]                    rem;
    logic [PW-1:0]                              p;
    logic [VMW-1:0]                             vm;
    logic                                       pooled_q;
    logic                                       relu_q;
    logic [SHIFT_W-1:0]                         shift_q;
    logic [X_MAC-1:0][ADDR_LEN-1:0]             addr;
    // pack0 collects the word for bank vm, pack1 for bank vm+1 (unpooled only)
    logic [X_MESH-1:0][DATA_LEN-1:0]            pack0;
    logic [X_MESH-1:0][DATA_LEN-1:0]            pack1;
    logic [X_MESH-1:0][X_MAC-1:0][DATA_LEN-1:0] data_q;
    logic [X_MESH-1:0][X_MAC-1:0][ADDR_LEN-1:0] addr_q;
    logic [X_MESH-1:0][X_MAC-1:0]               wea_q;
    logic                                       done_q;

    logic [X_MESH-1:0][3:0][OUT_BITS-1:0]       q4;
    logic [X_MESH-1:0][OUT_BITS-1:0]            q1;
    logic [X_MESH-1:0][DATA_LEN-1:0]            nxt0;
    logic [X_MESH-1:0][DATA_LEN-1:0]            nxt1;
    logic [MAX_LINE_LEN-1:0]                    rem_nxt;
    logic [VMW-1:0]                             vm1;
    logic                                       word_full;
    logic                                       last_beat;

    assign in_ready = (state == FILL);
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign wea      = wea_q;
    assign data_a   = data_q;
    assign addra    = addr_q;

    // Per-row quantisers, always fed with the configuration latched at conf.
    for (genvar r = 0; r < X_MESH; r++) begin : g_row
        for (genvar e = 0; e < 4; e++) begin : g_quad
            assign q4[r][e] = quant(in_data_4[(e + 4*r)*COM_DATALEN +: COM_DATALEN],
                                    shift_q, relu_q);
        end
        assign q1[r] = quant(in_data_1[r*COM_DATALEN +: COM_DATALEN], shift_q, relu_q);
    end

    always_comb begin
        vm1 = (vm == VMW'(X_MAC-1)) ? '0 : vm + VMW'(1);
        // Unpooled beats always consume two values, so an odd line ends at 0.
        if (pooled_q)
            rem_nxt = (rem > MAX_LINE_LEN'(1)) ? rem - MAX_LINE_LEN'(1) : '0;
        else
            rem_nxt = (rem > MAX_LINE_LEN'(2)) ? rem - MAX_LINE_LEN'(2) : '0;
        last_beat = (rem_nxt == '0);
        word_full = pooled_q ? (p == PW'(PACK-1)) : (p == PW'(PACK/2-1));
        for (int r = 0; r < X_MESH; r++) begin
            nxt0[r] = pack0[r];
            nxt1[r] = pack1[r];
            if (pooled_q) begin
                nxt0[r][p*OUT_BITS +: OUT_BITS] = q1[r];
            end else begin
                nxt0[r][2*p*OUT_BITS +: 2*OUT_BITS] = {q4[r][1], q4[r][0]};
                nxt1[r][2*p*OUT_BITS +: 2*OUT_BITS] = {q4[r][3], q4[r][2]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            p        <= '0;
            vm       <= '0;
            pooled_q <= 1'b0;
            relu_q   <= 1'b0;
            shift_q  <= '0;
            addr     <= '0;
            pack0    <= '0;
            pack1    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            wea_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            wea_q  <= '0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (conf) begin
                        vm       <= valid_mac;
                        pooled_q <= pooled;
                        relu_q   <= is_relu;
                        shift_q  <= shift_len;
                        rem      <= linelen;
                        addr     <= st_addr;
                        p        <= '0;
                        pack0    <= '0;
                        pack1    <= '0;
                        if (linelen == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        rem <= rem_nxt;
                        if (word_full || last_beat) begin
                            // Emit the word including this beat's lanes; any
                            // lanes not yet filled are still 0 from the clear.
                            p     <= '0;
                            pack0 <= '0;
                            pack1 <= '0;
                            for (int r = 0; r < X_MESH; r++) begin
                                data_q[r][vm] <= nxt0[r];
                                addr_q[r][vm] <= addr[vm];
                                wea_q[r][vm]  <= 1'b1;
                                if (!pooled_q) begin
                                    data_q[r][vm1] <= nxt1[r];
                                    addr_q[r][vm1] <= addr[vm1];
                                    wea_q[r][vm1]  <= 1'b1;
                                end
                            end
                            addr[vm] <= addr[vm] + ADDR_LEN'(1);
                            if (!pooled_q)
                                addr[vm1] <= addr[vm1] + ADDR_LEN'(1);
                        end else begin
                            p     <= p + PW'(1);
                            pack0 <= nxt0;
                            pack1 <= nxt1;
                        end
                        if (last_beat)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_write_pack_ctrl.sv
module tb_write_pack_ctrl;
    localparam int X_MAC = 4, X_MESH = 16, ADDR_LEN = 13, DATA_LEN = 32;
    localparam int COM = 24, OB = 8, MLL = 10, SW = 5;
    localparam int PACK = DATA_LEN / OB;
    localparam int VMW  = $clog2(X_MAC);
    localparam int SAW  = ADDR_LEN * X_MAC;
    localparam int NB   = X_MAC * X_MESH;

    logic                          clk = 1'b0;
    logic                          rst, conf, pooled, is_relu, in_valid;
    logic                          in_ready, busy, done;
    logic [SAW-1:0]                st_addr;
    logic [MLL-1:0]                linelen;
    logic [VMW-1:0]                valid_mac;
    logic [SW-1:0]                 shift_len;
    logic [4*COM*X_MESH-1:0]       in_data_4;
    logic [COM*X_MESH-1:0]         in_data_1;
    logic [ADDR_LEN*NB-1:0]        addra;
    logic [DATA_LEN*NB-1:0]        data_a;
    logic [NB-1:0]                 wea;

    write_pack_ctrl #(
        .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
        .COM_DATALEN(COM), .OUT_BITS(OB), .MAX_LINE_LEN(MLL), .SHIFT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .conf(conf), .st_addr(st_addr), .linelen(linelen),
        .valid_mac(valid_mac), .pooled(pooled), .shift_len(shift_len), .is_relu(is_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_data_4(in_data_4), .in_data_1(in_data_1),
        .addra(addra), .data_a(data_a), .wea(wea), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                                         cyc;
        logic [X_MAC-1:0]                           banks;
        logic [X_MAC-1:0][ADDR_LEN-1:0]             addr;
        logic [X_MESH-1:0][X_MAC-1:0][DATA_LEN-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  dv[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    wr_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference quantiser: integer arithmetic straight from the rules.
    function automatic logic [OB-1:0] qref(input logic [COM-1:0] x, input int sh, input bit rl);
        longint v, s, hi, lo;
        hi = (longint'(1) << (OB-1)) - 1;
        lo = -(longint'(1) << (OB-1));
        v  = longint'($signed(x));
`ifdef WPC_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh-1));
`endif
        s = v >>> sh;
        if (s > hi) return OB'(hi);
        if (s < 0 && rl) return '0;
        if (s < lo) return OB'(lo);
        return OB'(s);
    endfunction

    function automatic logic [COM-1:0] rnd_val();
        if ($urandom_range(1) == 1) return COM'($urandom);
        return COM'(int'($urandom_range(600)) - 300);
    endfunction

    function automatic logic [COM-1:0] dval(input int idx);
        if (idx < dv.size()) return COM'(dv[idx]);
        return '0;
    endfunction

    function automatic logic [SAW-1:0] rand_sa();
        return SAW'({$urandom, $urandom});
    endfunction

    // Monitor: every write and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (wea != '0) begin
            if (wq.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_write: wea=%0h with none expected (cycle %0d)", wea, cyc);
            end else begin
                mon_e = wq.pop_front();
                chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("wea", 64'(wea), 64'({X_MESH{mon_e.banks}}));
                for (int r = 0; r < X_MESH; r++)
                    for (int b = 0; b < X_MAC; b++)
                        if (mon_e.banks[b]) begin
                            chk($sformatf("data_r%0d_b%0d", r, b),
                                64'(data_a[(r*X_MAC+b)*DATA_LEN +: DATA_LEN]), 64'(mon_e.data[r][b]));
                            chk($sformatf("addr_r%0d_b%0d", r, b),
                                64'(addra[(r*X_MAC+b)*ADDR_LEN +: ADDR_LEN]), 64'(mon_e.addr[b]));
                        end
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with none expected (cycle %0d)", cyc);
            end else begin
                chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
            end
        end
    end

    // Drive one line and predict its writes. abort_at>0 resets the DUT before
    // that beat; midconf pulses a bogus conf while the line is filling.
    task automatic run_line(input bit pl, input int vmi, input int lin, input int sh, input bit rl,
                            input logic [SAW-1:0] sa, input bit dir, input int vprob,
                            input bit midconf, input int abort_at);
        int nb, n, epb, slot, b1;
        bit full, mc_done;
        int ma [X_MAC];
        logic [DATA_LEN-1:0] acc0 [X_MESH];
        logic [DATA_LEN-1:0] acc1 [X_MESH];
        logic [COM-1:0] v [X_MESH][4];
        wr_t we;
        epb = pl ? 1 : 4;
        nb  = pl ? lin : (lin + 1) / 2;
        b1  = (vmi + 1) % X_MAC;
        for (int b = 0; b < X_MAC; b++) ma[b] = int'(sa[b*ADDR_LEN +: ADDR_LEN]);
        for (int r = 0; r < X_MESH; r++) begin acc0[r] = '0; acc1[r] = '0; end

        @(negedge clk);
        conf = 1'b1; pooled = pl; valid_mac = VMW'(vmi); linelen = MLL'(lin);
        shift_len = SW'(sh); is_relu = rl; st_addr = sa;
        if (lin == 0) dq.push_back(cyc + 1);
        @(negedge clk);
        // Scramble config inputs: only the values latched at conf may matter.
        conf = 1'b0; pooled = 1'($urandom_range(1)); valid_mac = VMW'($urandom);
        linelen = MLL'($urandom); shift_len = SW'($urandom); is_relu = 1'($urandom_range(1));
        st_addr = rand_sa();

        n = 0;
        mc_done = 1'b0;
        while (n < nb) begin
            if (abort_at > 0 && n == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_in_ready", 64'(in_ready), 64'd0);
                chk("abort_wea", 64'(wea), 64'd0);
                return;
            end
            conf = 1'b0;
            if (midconf && n == 1 && !mc_done) begin
                conf = 1'b1; mc_done = 1'b1; linelen = MLL'(2);
                st_addr = rand_sa(); pooled = ~pl;
            end
            if (int'($urandom_range(99)) < vprob) begin
                chk("in_ready", 64'(in_ready), 64'd1);
                for (int r = 0; r < X_MESH; r++) begin
                    for (int k = 0; k < 4; k++) v[r][k] = dir ? dval(n*epb + k) : rnd_val();
                    if (pl) begin
                        in_data_1[r*COM +: COM] = v[r][0];
                        for (int k = 0; k < 4; k++) in_data_4[(k + 4*r)*COM +: COM] = rnd_val();
                    end else begin
                        in_data_1[r*COM +: COM] = rnd_val();
                        for (int k = 0; k < 4; k++) in_data_4[(k + 4*r)*COM +: COM] = v[r][k];
                    end
                end
                in_valid = 1'b1;
                if (pl) begin
                    slot = n % PACK;
                    for (int r = 0; r < X_MESH; r++)
                        acc0[r] = acc0[r] | (DATA_LEN'(qref(v[r][0], sh, rl)) << (slot*OB));
                    full = (slot == PACK-1) || (n == nb-1);
                end else begin
                    slot = n % (PACK/2);
                    for (int r = 0; r < X_MESH; r++) begin
                        acc0[r] = acc0[r] | (DATA_LEN'({qref(v[r][1], sh, rl), qref(v[r][0], sh, rl)}) << (2*slot*OB));
                        acc1[r] = acc1[r] | (DATA_LEN'({qref(v[r][3], sh, rl), qref(v[r][2], sh, rl)}) << (2*slot*OB));
                    end
                    full = (slot == PACK/2-1) || (n == nb-1);
                end
                if (full) begin
                    we.cyc = cyc + 1;
                    we.banks = '0;
                    we.addr = '0;
                    we.data = '0;
                    we.banks[vmi] = 1'b1;
                    we.addr[vmi] = ADDR_LEN'(ma[vmi]);
                    ma[vmi] = (ma[vmi] + 1) % (1 << ADDR_LEN);
                    for (int r = 0; r < X_MESH; r++) we.data[r][vmi] = acc0[r];
                    if (!pl) begin
                        we.banks[b1] = 1'b1;
                        we.addr[b1] = ADDR_LEN'(ma[b1]);
                        ma[b1] = (ma[b1] + 1) % (1 << ADDR_LEN);
                        for (int r = 0; r < X_MESH; r++) we.data[r][b1] = acc1[r];
                    end
                    wq.push_back(we);
                    for (int r = 0; r < X_MESH; r++) begin acc0[r] = '0; acc1[r] = '0; end
                end
                if (n == nb-1) dq.push_back(cyc + 2);
                n++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        conf = 1'b0;
        chk("tail_in_ready", 64'(in_ready), 64'd0);
        chk("tail_busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [SAW-1:0] sa;
        rst = 1'b1; conf = 1'b0; pooled = 1'b0; is_relu = 1'b0; in_valid = 1'b0;
        st_addr = '0; linelen = '0; valid_mac = '0; shift_len = '0;
        in_data_4 = '0; in_data_1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_wea", 64'(wea), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_data_lo", data_a[63:0], 64'd0);
        chk("reset_addr_lo", 64'(addra[51:0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // pooled 1,2,3,4 -> 0x04030201 in bank 2
        dv = '{1, 2, 3, 4};
        run_line(1'b1, 2, 4, 0, 1'b0, rand_sa(), 1'b1, 100, 1'b0, 0);

        // unpooled quads, bank 3 + wrapped bank 0, bank 3 address wraps 0x1FFF -> 0
        dv = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};
        sa = rand_sa();
        sa[3*ADDR_LEN +: ADDR_LEN] = '1;
        run_line(1'b0, 3, 6, 0, 1'b0, sa, 1'b1, 100, 1'b0, 0);

        // saturation, without and with ReLU
        dv = '{8388607, -8388607, -32};
        run_line(1'b1, 0, 3, 4, 1'b0, rand_sa(), 1'b1, 100, 1'b0, 0);
        run_line(1'b1, 1, 3, 4, 1'b1, rand_sa(), 1'b1, 100, 1'b0, 0);

        // random in_valid with an ignored mid-line conf
        run_line(1'b1, 2, 8, 0, 1'b0, rand_sa(), 1'b0, 50, 1'b1, 0);

        // empty line, then a reset after two beats
        run_line(1'b1, 1, 0, 0, 1'b0, rand_sa(), 1'b0, 100, 1'b0, 0);
        run_line(1'b1, 0, 8, 0, 1'b0, rand_sa(), 1'b0, 100, 1'b0, 2);
        @(negedge clk);

        // rounding behaviour (tracks WPC_ROUND_EN)
        dv = '{6, -6};
        run_line(1'b1, 3, 2, 2, 1'b0, rand_sa(), 1'b1, 100, 1'b0, 0);

        // odd unpooled line ending on a partial quad
        run_line(1'b0, 1, 5, 3, 1'b1, rand_sa(), 1'b0, 70, 1'b0, 0);

        for (int t = 0; t < 20; t++)
            run_line(1'($urandom_range(1)), int'($urandom_range(X_MAC-1)), int'($urandom_range(40, 1)),
                     int'($urandom_range(12)), 1'($urandom_range(1)), rand_sa(), 1'b0,
                     int'($urandom_range(100, 30)), 1'b0, 0);

        repeat (4) @(negedge clk);
        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("pending_done", 64'(dq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/write_pack_ctrl.md
Name: write_pack_ctrl

Overview:
Parametrised successor to the mesh-result write controller. It takes accumulator results from the X_MESH rows, then requantises them with an arithmetic shift, optional ReLU and saturation to OUT_BITS. It packs PACK = DATA_LEN/OUT_BITS values per word and writes the words into X_MAC buffer banks per row. It sits between the compute mesh and the feature-map buffers, and it adds a valid/ready handshake, configurable output width, partial-word flush and a done pulse.

Parameters:
X_MAC, 4, banks per mesh row
X_MESH, 16, mesh rows
ADDR_LEN, 13, bank address width
DATA_LEN, 32, bank word width
COM_DATALEN, 24, accumulator width
OUT_BITS, 8, quantised value width; DATA_LEN must be a multiple of 2*OUT_BITS
MAX_LINE_LEN, 10, width of linelen
SHIFT_W, 5, width of shift_len

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
conf  in  1  one-cycle config strobe; accepted only in IDLE
st_addr  in  ADDR_LEN*X_MAC  start address per bank
linelen  in  MAX_LINE_LEN  number of values per row in this line
valid_mac  in  clog2(X_MAC)  primary bank select
pooled  in  1  1 = one value per beat; 0 = 2x2 quad per beat
shift_len  in  SHIFT_W  right-shift amount
is_relu  in  1  clamp negative values to 0
in_valid  in  1  input beat valid
in_ready  out  1  controller accepts beat
in_data_4  in  4*COM_DATALEN*X_MESH  quad per row, index k + 2*j + 4*row
in_data_1  in  COM_DATALEN*X_MESH  single value per row
addra  out  ADDR_LEN*X_MAC*X_MESH  bank addresses, bank b of row r at (r*X_MAC+b)*ADDR_LEN
data_a  out  DATA_LEN*X_MAC*X_MESH  bank write data, same layout
wea  out  X_MAC*X_MESH  bank write enables
busy  out  1  line in progress
done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset: all outputs 0; state IDLE; pack registers and counters cleared. A reset mid-line aborts the line with no further writes.
- conf in IDLE latches all config inputs, sets the remaining count to linelen, sets the per-bank address to st_addr, and enters FILL. conf outside IDLE is ignored.
- Beat accepted = in_valid && in_ready. in_ready = (state==FILL).
- Quantise (combinational, per value): s = x >>> shift_len, arithmetic. If s > 2^(OUT_BITS-1)-1, saturate to the max. If s < 0 and is_relu, output 0. If s < -2^(OUT_BITS-1), saturate to the min. Otherwise output s truncated to OUT_BITS.
- Pooled mode:
  - Each beat writes the row's in_data_1 value into lane p (bits p*OUT_BITS) of bank valid_mac.
  - p counts 0..PACK-1. The remaining count decrements by 1.
- Unpooled mode:
  - Bank valid_mac receives {q[0][1],q[0][0]} at lanes 2p, 2p+1.
  - Bank (valid_mac+1) mod X_MAC receives {q[1][1],q[1][0]} at the same lanes. This wraps from X_MAC-1 to 0.
  - p counts 0..PACK/2-1. The remaining count decrements by 2, saturating at 0, so an odd linelen consumes a full final quad.
- Word complete (p at last lane), or remaining reaches 0:
  - On the next cycle, wea=1 for the target banks in every row, with data_a = packed word and addra = current address.
  - The address increments by 1 after the write, wrapping at 2^ADDR_LEN.
  - p resets and the pack register clears to 0.
- Partial word at end of line: unused upper lanes are written as 0.
- After the final beat, the state moves to FLUSH for one cycle (write issued), then DONE for one cycle (done=1), then IDLE.
- linelen=0: conf goes IDLE -> DONE directly; no writes occur.
- Latency: beat to wea is 1 cycle. wea is never asserted for non-target banks.
- busy = state != IDLE. Every write carries a complete word; there are no byte enables.

Optional Feature:
ROUND_EN_EN is not used; the macro is WPC_ROUND_EN.
- Defined: before the shift, add 2^(shift_len-1) when shift_len>0, giving round-half-up. The add is computed at COM_DATALEN+1 bits so it cannot overflow, then saturated as above.
- Undefined: plain truncating arithmetic shift.

Test Plan:
1. Pooled, valid_mac=2, linelen=4, shift 0, values 1,2,3,4 -> one write to bank 2 of every row at st_addr, data 0x04030201, then done pulse.
2. Unpooled, valid_mac=3, linelen=6, quads (1,2,3,4) x3 -> bank 3 gets 0x02010201 and bank 0 gets 0x04030403 at st_addr. The last quad is written at st_addr+1 with upper half 0, confirming wrap 3->0.
3. Saturation: shift 4, inputs 0x7FFFFF, -0x7FFFFF, -32 with is_relu=0 -> 127, -128, -2. With is_relu=1 -> 127, 0, 0.
4. Handshake: in_valid toggled randomly, linelen=8 pooled -> exactly 2 writes with no dropped or duplicated lanes. A conf pulse mid-line is ignored.
5. linelen=0 -> done one cycle after conf, no wea. rst asserted after 2 beats -> no wea, IDLE next cycle.
6. With WPC_ROUND_EN: shift 2, input 6 -> 2, input -6 -> -1. Without it: 1 and -2.
